// File: rtl/iob_axistream_out_pack_pkg.sv
// iob_axistream_out_pack_pkg
//   Shared definitions for the CPU-to-AXI-Stream packer: register word
//   addresses, STATUS bit positions, serializer state encoding and the
//   beats-per-word helper.
package iob_axistream_out_pack_pkg;

    // CPU register map (word addresses)
    localparam int REG_DATA      = 0;
    localparam int REG_DATA_LAST = 1;
    localparam int REG_STATUS    = 2;
    localparam int REG_CLEAR     = 3;

    // STATUS register layout; level occupies FIFO_DEPTH_LOG2+1 bits from STATUS_LEVEL
    localparam int STATUS_FULL     = 0;
    localparam int STATUS_EMPTY    = 1;
    localparam int STATUS_OVERFLOW = 2;
    localparam int STATUS_LEVEL    = 3;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_t;

    function automatic int beats_per_word(input int data_w, input int tdata_w);
        return data_w / tdata_w;
    endfunction

endpackage

// File: rtl/iob_axistream_out_pack_fifo.sv
// iob_axistream_out_pack_fifo
//   Synchronous show-ahead FIFO. The entry at the read pointer is always
//   presented on head_data, so a consumer can take it in the same cycle it
//   asserts pop. A push while full is dropped (full is judged before any
//   same-cycle pop). clear empties the FIFO and wins over push/pop.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   clear       flush all entries
//   push        write push_data (ignored when full)
//   push_data   entry to store
//   pop         drop the head entry (ignored when empty)
//   head_data   current head entry
//   empty/full  occupancy flags
//   level       number of stored entries, 0..2^DEPTH_LOG2
module iob_axistream_out_pack_fifo
    import iob_axistream_out_pack_pkg::*;
#(
    parameter int W          = 33,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                push,
    input  logic [W-1:0]        push_data,
    input  logic                pop,
    output logic [W-1:0]        head_data,
    output logic                empty,
    output logic                full,
    output logic [DEPTH_LOG2:0] level
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int LVL_W = DEPTH_LOG2 + 1;

    logic [W-1:0]          mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign empty     = (level == '0);
    assign full      = (level == LVL_W'(DEPTH));
    assign do_push   = push & ~full;
    assign do_pop    = pop & ~empty;
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers are exactly DEPTH_LOG2 bits wide, so they wrap modulo depth.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            if (do_pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/iob_axistream_out_pack.sv
// iob_axistream_out_pack
//   CPU-written AXI-Stream master. DATA_W-bit words written over the iob
//   bus are queued in a FIFO and serialized into DATA_W/TDATA_W beats,
//   least-significant beat first. Words written to DATA_LAST mark their
//   final beat with tlast.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   valid/address/wdata/wstrb iob request (any wstrb bit set = write)
//   rdata/ready              registered iob response, one cycle after valid
//   tdata/tvalid/tready/tlast AXI-Stream master
//   irq_idle                 FIFO empty and serializer idle (registered)
module iob_axistream_out_pack #(
    parameter int DATA_W          = 32,
    parameter int TDATA_W         = 8,
    parameter int FIFO_DEPTH_LOG2 = 4,
    parameter int ADDR_W          = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    output logic [DATA_W-1:0]   rdata,
    output logic                ready,
    output logic [TDATA_W-1:0]  tdata,
    output logic                tvalid,
    input  logic                tready,
    output logic                tlast,
    output logic                irq_idle
);
    import iob_axistream_out_pack_pkg::*;

    localparam int N     = beats_per_word(DATA_W, TDATA_W);
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int LVL_W = FIFO_DEPTH_LOG2 + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N - 1);

    if (!((TDATA_W == 8 || TDATA_W == 16 || TDATA_W == 32) && (DATA_W % TDATA_W == 0)))
    begin : g_bad_tdata_w
        $error("iob_axistream_out_pack: TDATA_W must be 8, 16 or 32 and divide DATA_W");
    end

    if (DATA_W < STATUS_LEVEL + LVL_W) begin : g_bad_status_w
        $error("iob_axistream_out_pack: DATA_W too narrow for STATUS level field");
    end

    // ---------------- register decode ----------------
    logic wr_en, rd_en, push, clear, status_rd;

    always_comb begin
        wr_en     = valid & (|wstrb);
        rd_en     = valid & ~(|wstrb);
        push      = wr_en & ((address == ADDR_W'(REG_DATA)) |
                             (address == ADDR_W'(REG_DATA_LAST)));
        clear     = wr_en & (address == ADDR_W'(REG_CLEAR));
        status_rd = rd_en & (address == ADDR_W'(REG_STATUS));
    end

    // ---------------- FIFO ----------------
    logic [DATA_W:0]  head_data;
    logic             pop, empty, full;
    logic [LVL_W-1:0] level;

    iob_axistream_out_pack_fifo #(
        .W          (DATA_W + 1),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .push      (push),
        .push_data ({address == ADDR_W'(REG_DATA_LAST), wdata}),
        .pop       (pop),
        .head_data (head_data),
        .empty     (empty),
        .full      (full),
        .level     (level)
    );

    // ---------------- status / bus response ----------------
    logic              overflow;
    logic [DATA_W-1:0] status_word;

    always_comb begin
        status_word                          = '0;
        status_word[STATUS_FULL]             = full;
        status_word[STATUS_EMPTY]            = empty;
        status_word[STATUS_OVERFLOW]         = overflow;
        status_word[STATUS_LEVEL +: LVL_W]   = level;
    end

    ser_state_t state, state_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            ready    <= 1'b0;
            rdata    <= '0;
            overflow <= 1'b0;
            irq_idle <= 1'b1;
        end else begin
            ready    <= valid;
            rdata    <= status_rd ? status_word : '0;
            // A fresh overflow beats the clear-on-read of STATUS.
            if (clear)             overflow <= 1'b0;
            else if (push && full) overflow <= 1'b1;
            else if (status_rd)    overflow <= 1'b0;
            irq_idle <= empty & (state == IDLE);
        end
    end

    // ---------------- serializer ----------------
    logic [DATA_W-1:0] shift;
    logic [CNT_W-1:0]  beat_cnt;
    logic              last_flag;
    logic              load, advance;
    logic              at_last;

    assign at_last = (beat_cnt == LAST_BEAT);

    always_comb begin
        state_n = state;
        pop     = 1'b0;
        load    = 1'b0;
        advance = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    load    = 1'b1;
                    state_n = SEND;
                end
            end
            SEND: begin
                if (tready) begin
                    if (!at_last) begin
                        advance = 1'b1;
                    end else if (!empty) begin
                        // back-to-back reload keeps 1 beat/cycle
                        pop  = 1'b1;
                        load = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        // Flush aborts whatever is in flight, including a pending pop.
        if (clear) begin
            state_n = IDLE;
            pop     = 1'b0;
            load    = 1'b0;
            advance = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shift     <= '0;
            beat_cnt  <= '0;
            last_flag <= 1'b0;
        end else begin
            state <= state_n;
            if (load) begin
                shift     <= head_data[DATA_W-1:0];
                last_flag <= head_data[DATA_W];
                beat_cnt  <= '0;
            end else if (advance) begin
                shift    <= shift >> TDATA_W;
                beat_cnt <= beat_cnt + CNT_W'(1);
            end
        end
    end

    // Outputs are forced to zero outside SEND so reset/flush leave a clean bus.
    assign tvalid = (state == SEND);
    assign tdata  = tvalid ? shift[TDATA_W-1:0] : '0;
    assign tlast  = tvalid & last_flag & at_last;

endmodule

// File: tb/tb_iob_axistream_out_pack.sv
// Bench for iob_axistream_out_pack: three instances (beat widths 8, 16, 32,
// FIFO depth 4) share one CPU bus and one tready. A beat-level scoreboard
// derived from each written word checks every handshake; directed steps
// check latency, status, flush and reset behaviour.
module tb_iob_axistream_out_pack;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 2;
    localparam int DLOG2  = 2;

    logic clk = 1'b0, rst = 1'b1, valid = 1'b0, tready = 1'b0;
    logic [ADDR_W-1:0]   address = '0;
    logic [DATA_W-1:0]   wdata   = '0;
    logic [DATA_W/8-1:0] wstrb   = '0;

    logic [DATA_W-1:0] rdata0, rdata1, rdata2;
    logic ready0, ready1, ready2, tvalid0, tvalid1, tvalid2;
    logic tlast0, tlast1, tlast2, irq0, irq1, irq2;
    logic [7:0]  tdata0;
    logic [15:0] tdata1;
    logic [31:0] tdata2;

    iob_axistream_out_pack #(.DATA_W(DATA_W), .TDATA_W(8), .FIFO_DEPTH_LOG2(DLOG2), .ADDR_W(ADDR_W)) u_dut8 (
        .clk(clk), .rst(rst), .valid(valid), .address(address), .wdata(wdata), .wstrb(wstrb),
        .rdata(rdata0), .ready(ready0), .tdata(tdata0), .tvalid(tvalid0), .tready(tready),
        .tlast(tlast0), .irq_idle(irq0));
    iob_axistream_out_pack #(.DATA_W(DATA_W), .TDATA_W(16), .FIFO_DEPTH_LOG2(DLOG2), .ADDR_W(ADDR_W)) u_dut16 (
        .clk(clk), .rst(rst), .valid(valid), .address(address), .wdata(wdata), .wstrb(wstrb),
        .rdata(rdata1), .ready(ready1), .tdata(tdata1), .tvalid(tvalid1), .tready(tready),
        .tlast(tlast1), .irq_idle(irq1));
    iob_axistream_out_pack #(.DATA_W(DATA_W), .TDATA_W(32), .FIFO_DEPTH_LOG2(DLOG2), .ADDR_W(ADDR_W)) u_dut32 (
        .clk(clk), .rst(rst), .valid(valid), .address(address), .wdata(wdata), .wstrb(wstrb),
        .rdata(rdata2), .ready(ready2), .tdata(tdata2), .tvalid(tvalid2), .tready(tready),
        .tlast(tlast2), .irq_idle(irq2));

    always #5 clk = ~clk;

    logic [2:0]  tv, tl, irq, rdy;
    logic [31:0] tdv [3];
    logic [31:0] rdv [3];
    always_comb begin
        tv     = {tvalid2, tvalid1, tvalid0};
        tl     = {tlast2, tlast1, tlast0};
        irq    = {irq2, irq1, irq0};
        rdy    = {ready2, ready1, ready0};
        tdv[0] = {24'b0, tdata0};
        tdv[1] = {16'b0, tdata1};
        tdv[2] = tdata2;
        rdv[0] = rdata0;
        rdv[1] = rdata1;
        rdv[2] = rdata2;
    end

    int n_tests = 0;
    int n_fail  = 0;
    bit rand_ready = 1'b0;
    logic [32:0] exp_q [3][$];
    int hs_cnt [3] = '{0, 0, 0};
    int hs_base [3];
    logic        prev_stall [3] = '{1'b0, 1'b0, 1'b0};
    logic [32:0] prev_beat  [3];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected beats of one word: LSB slice first, tlast only on the final
    // slice of a DATA_LAST word.
    function automatic void model_push(input logic [31:0] word, input logic last);
        int w, n;
        logic [63:0] mask;
        logic [31:0] beat;
        for (int k = 0; k < 3; k++) begin
            w    = 8 << k;
            n    = DATA_W / w;
            mask = (64'd1 << w) - 64'd1;
            for (int b = 0; b < n; b++) begin
                beat = 32'((64'(word) >> (b * w)) & mask);
                exp_q[k].push_back({last && (b == n - 1), beat});
            end
        end
    endfunction

    function automatic void model_flush();
        for (int k = 0; k < 3; k++) exp_q[k].delete();
    endfunction

    // Stream scoreboard: sampled mid-cycle, the handshake lands on the next edge.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst && tv[k]) begin
                if (prev_stall[k]) chk($sformatf("hold_%0d", k), {tl[k], tdv[k]}, prev_beat[k]);
                if (tready) begin
                    hs_cnt[k] <= hs_cnt[k] + 1;
                    n_tests++;
                    assert (exp_q[k].size() != 0) else begin
                        n_fail++;
                        $error("FAIL extra_beat_%0d: observed %0h expected none", k, {tl[k], tdv[k]});
                    end
                    if (exp_q[k].size() != 0)
                        chk($sformatf("beat_%0d", k), {tl[k], tdv[k]}, exp_q[k].pop_front());
                end
            end
            prev_stall[k] <= !rst && tv[k] && !tready;
            prev_beat[k]  <= {tl[k], tdv[k]};
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_ready) tready = 1'($urandom_range(0, 1));
    endtask

    task automatic bus_write(input int addr, input logic [31:0] data, input bit accept);
        valid = 1'b1; address = ADDR_W'(addr); wdata = data; wstrb = '1;
        if (accept && (addr == 0 || addr == 1)) model_push(data, addr == 1);
        step();
        chk("wr_ready", 64'(rdy), 64'h7);
        valid = 1'b0; wstrb = '0;
        step();
        chk("wr_ready_drop", 64'(rdy), 64'h0);
    endtask

    task automatic bus_read(input int addr, input logic [31:0] exp, input string tag);
        valid = 1'b1; address = ADDR_W'(addr); wstrb = '0;
        step();
        chk({tag, "_ready"}, 64'(rdy), 64'h7);
        for (int k = 0; k < 3; k++) chk($sformatf("%s_%0d", tag, k), 64'(rdv[k]), 64'(exp));
        valid = 1'b0;
        step();
    endtask

    task automatic wait_idle(input string tag);
        int c = 0;
        while (c < 400 && !(exp_q[0].size() == 0 && exp_q[1].size() == 0 && exp_q[2].size() == 0
                            && tv == 3'b000 && irq == 3'b111)) begin
            step();
            c++;
        end
        chk({tag, "_drained"}, 64'(c < 400), 64'd1);
    endtask

    task automatic snap();
        for (int k = 0; k < 3; k++) hs_base[k] = hs_cnt[k];
    endtask

    task automatic chk_beats(input string tag, input int e0, input int e1, input int e2);
        step();
        chk({tag, "_n8"},  64'(hs_cnt[0] - hs_base[0]), 64'(e0));
        chk({tag, "_n16"}, 64'(hs_cnt[1] - hs_base[1]), 64'(e1));
        chk({tag, "_n32"}, 64'(hs_cnt[2] - hs_base[2]), 64'(e2));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // ---- reset state
        rst = 1'b1;
        repeat (3) step();
        chk("rst_tvalid", 64'(tv), 0);
        chk("rst_tlast", 64'(tl), 0);
        chk("rst_ready", 64'(rdy), 0);
        chk("rst_irq", 64'(irq), 64'h7);
        for (int k = 0; k < 3; k++) begin
            chk("rst_tdata", 64'(tdv[k]), 0);
            chk("rst_rdata", 64'(rdv[k]), 0);
        end
        rst = 1'b0;
        step();
        bus_read(2, 32'h2, "idle_status");

        // ---- single DATA_LAST word: latency, beat order, tlast placement
        tready = 1'b1;
        valid = 1'b1; address = 2'd1; wdata = 32'h44332211; wstrb = '1;
        model_push(32'h44332211, 1'b1);
        step();
        chk("t1_not_yet", 64'(tv), 0);
        valid = 1'b0; wstrb = '0;
        step();
        chk("t1_tvalid", 64'(tv), 64'h7);
        chk("t1_w32", 64'({tl[2], tdv[2]}), 64'({1'b1, 32'h44332211}));
        chk("t1_w16", 64'({tl[1], tdv[1]}), 64'({1'b0, 32'h2211}));
        for (int i = 0; i < 4; i++) begin
            chk("t1_beat8", 64'({tl[0], tdv[0]}), 64'({i == 3, 32'(8'h11 * (i + 1))}));
            if (i == 1) chk("t1_irq_busy", 64'(irq[0]), 0);
            step();
        end
        chk("t1_end", 64'(tv[0]), 0);
        wait_idle("t1");

        // ---- back-to-back writes, full-width beats without bubbles
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                valid = 1'b1; address = 2'd0; wdata = 32'(i + 1); wstrb = '1;
                model_push(32'(i + 1), 1'b0);
            end else begin
                valid = 1'b0; wstrb = '0;
            end
            step();
            if (i >= 1 && i <= 4) chk("t2_beat", 64'({tv[2], tl[2], tdv[2]}), 64'({2'b10, 32'(i)}));
            else if (i == 5) chk("t2_end", 64'(tv[2]), 0);
        end
        wait_idle("t2");

        // ---- backpressure 1,0,0 pattern
        snap();
        tready = 1'b0;
        bus_write(1, 32'hAABBCCDD, 1'b1);
        for (int i = 0; i < 12; i++) begin
            tready = (i % 3 == 0);
            step();
        end
        tready = 1'b1;
        wait_idle("t3");
        chk_beats("t3", 4, 2, 1);

        // ---- overflow: serializer holds one word, FIFO four, sixth dropped
        snap();
        tready = 1'b0;
        for (int i = 0; i < 6; i++) bus_write(0, $urandom, i < 5);
        bus_read(2, 32'h25, "t4_status1");
        bus_read(2, 32'h21, "t4_status2");
        bus_read(0, 32'h0, "t4_rd_data");
        bus_read(3, 32'h0, "t4_rd_clear");
        bus_write(2, 32'hFFFF_FFFF, 1'b0);
        bus_read(2, 32'h21, "t4_status3");
        tready = 1'b1;
        wait_idle("t4");
        chk_beats("t4", 20, 10, 5);

        // ---- flush in the middle of a stalled packet
        tready = 1'b0;
        for (int i = 0; i < 3; i++) bus_write(0, $urandom, 1'b1);
        valid = 1'b1; address = 2'd3; wdata = '0; wstrb = '1;
        step();
        model_flush();
        chk("t5_tvalid", 64'(tv), 0);
        chk("t5_tlast", 64'(tl), 0);
        valid = 1'b0; wstrb = '0;
        step();
        bus_read(2, 32'h2, "t5_status");
        tready = 1'b1;
        bus_write(0, 32'h0000_00EE, 1'b1);
        chk("t5_first8", 64'({tv[0], tdv[0]}), 64'({1'b1, 32'hEE}));
        chk("t5_first16", 64'({tv[1], tdv[1]}), 64'({1'b1, 32'hEE}));
        wait_idle("t5");

        // ---- reset during a burst
        tready = 1'b1;
        bus_write(1, $urandom, 1'b1);
        bus_write(0, $urandom, 1'b1);
        rst = 1'b1;
        model_flush();
        step();
        chk("t6_tvalid", 64'(tv), 0);
        chk("t6_tlast", 64'(tl), 0);
        chk("t6_irq", 64'(irq), 64'h7);
        chk("t6_tdata8", 64'(tdv[0]), 0);
        rst = 1'b0;
        step();
        snap();
        bus_read(2, 32'h2, "t6_status");
        repeat (20) step();
        chk_beats("t6", 0, 0, 0);

        // ---- random words, random last flags, random tready
        rand_ready = 1'b1;
        for (int r = 0; r < 8; r++) begin
            int nw;
            nw = $urandom_range(1, 4);
            for (int i = 0; i < nw; i++) bus_write($urandom_range(0, 1), $urandom, 1'b1);
            wait_idle("rand");
        end
        rand_ready = 1'b0;
        tready = 1'b1;
        bus_read(2, 32'h2, "rand_status");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
